// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter: FSM state encoding,
// one-hot grant codes and the fixed-priority selection helper.
package memory_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic logic [1:0] fixed_pick(input logic [1:0] req);
    if (req[0]) return GRANT_M0;
    if (req[1]) return GRANT_M1;
    return GRANT_NONE;
  endfunction

endpackage

// File: rtl/arbiter_priority.sv
// Combinational winner selection between the two masters' requests.
// ARBITER_ROUND_ROBIN_EN: ties go to the master not served last; otherwise m0 always wins.
module arbiter_priority
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);

`ifdef ARBITER_ROUND_ROBIN_EN
  // last = 1 means m1 was served most recently, so m0 takes the tie.
  always_comb begin
    winner = fixed_pick(req);
    if (req == 2'b11) winner = last ? GRANT_M0 : GRANT_M1;
  end
`else
  logic w_unused_last;
  assign w_unused_last = last;
  assign winner        = fixed_pick(req);
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares one rd_en/wr_en/busy memory slave between m0 (core) and m1 (DMA/debug).
// Define ARBITER_ROUND_ROBIN_EN for round-robin ties; default build is fixed priority (m0).
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter  int unsigned ADDR_W   = ADDR_W_DEF,
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  localparam int unsigned BYTE_NUM = DATA_W / 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                m0_rd_en,
  input  logic                m0_wr_en,
  input  logic [BYTE_NUM-1:0] m0_byte_en,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wr_data,
  output logic                m0_busy,
  input  logic                m1_rd_en,
  input  logic                m1_wr_en,
  input  logic [BYTE_NUM-1:0] m1_byte_en,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wr_data,
  output logic                m1_busy,
  output logic [DATA_W-1:0]   rd_data,
  output logic                mem_rd_en,
  output logic                mem_wr_en,
  output logic [BYTE_NUM-1:0] mem_byte_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  input  logic [DATA_W-1:0]   mem_rd_data,
  input  logic                mem_busy,
  output logic [1:0]          grant
);

  arb_state_e r_state, w_next_state;
  logic [1:0] r_grant, w_next_grant;
  logic [1:0] w_req;
  logic [1:0] w_winner;
  logic       w_last;

  assign w_req = {m1_rd_en | m1_wr_en, m0_rd_en | m0_wr_en};

  arbiter_priority u_priority (
    .req    (w_req),
    .last   (w_last),
    .winner (w_winner)
  );

`ifdef ARBITER_ROUND_ROBIN_EN
  logic r_last;

  // The pointer moves only on a completed transaction; an aborted grant leaves it alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (r_state == ST_BUSY && !mem_busy) begin
      r_last <= r_grant[1];
    end
  end

  assign w_last = r_last;
`else
  assign w_last = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= GRANT_NONE;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_next_state = ST_REQ;
          w_next_grant = w_winner;
        end
      end
      ST_REQ: begin
        if (mem_busy) begin
          w_next_state = ST_BUSY;
        end else if ((w_req & r_grant) == 2'b00) begin
          w_next_state = ST_IDLE;
          w_next_grant = GRANT_NONE;
        end
      end
      ST_BUSY: begin
        if (!mem_busy) begin
          w_next_state = ST_IDLE;
          w_next_grant = GRANT_NONE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_grant = GRANT_NONE;
      end
    endcase
  end

  // Grant is cleared in IDLE, so the slave sees all zeros whenever nobody owns it.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_byte_en = '0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (r_grant[0]) begin
      mem_rd_en   = m0_rd_en;
      mem_wr_en   = m0_wr_en;
      mem_byte_en = m0_byte_en;
      mem_addr    = m0_addr;
      mem_wr_data = m0_wr_data;
    end else if (r_grant[1]) begin
      mem_rd_en   = m1_rd_en;
      mem_wr_en   = m1_wr_en;
      mem_byte_en = m1_byte_en;
      mem_addr    = m1_addr;
      mem_wr_data = m1_wr_data;
    end
  end

  assign m0_busy = mem_busy & r_grant[0];
  assign m1_busy = mem_busy & r_grant[1];
  assign rd_data = mem_rd_data;
  assign grant   = r_grant;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a behavioural slave pops expected transactions as it
// accepts them; honours ARBITER_ROUND_ROBIN_EN for tie ordering.
`timescale 1ns/1ps
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int BN   = 8;
  localparam int HALF = 10;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [BN-1:0] be;
    logic [DW-1:0] wd;
    logic [DW-1:0] rdata;
    logic [1:0]    grant;
    int            blen;
  } txn_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          m_rd   [2];
  logic          m_wr   [2];
  logic [BN-1:0] m_be   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wd   [2];
  logic          m0_busy, m1_busy;
  logic [DW-1:0] rd_data;
  logic          mem_rd_en, mem_wr_en;
  logic [BN-1:0] mem_byte_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          mem_busy;
  logic [1:0]    grant;

  int   checks   = 0;
  int   failures = 0;
  txn_t sb_q[$];
  int   s_cnt;
  logic s_active;
  bit   ok_a, ok_b, ok_c;

  always #HALF clock = ~clock;

  memory_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .m0_rd_en    (m_rd[0]),
    .m0_wr_en    (m_wr[0]),
    .m0_byte_en  (m_be[0]),
    .m0_addr     (m_addr[0]),
    .m0_wr_data  (m_wd[0]),
    .m0_busy     (m0_busy),
    .m1_rd_en    (m_rd[1]),
    .m1_wr_en    (m_wr[1]),
    .m1_byte_en  (m_be[1]),
    .m1_addr     (m_addr[1]),
    .m1_wr_data  (m_wd[1]),
    .m1_busy     (m1_busy),
    .rd_data     (rd_data),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_byte_en (mem_byte_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_busy    (mem_busy),
    .grant       (grant)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input int m);
    return (m == 0) ? m0_busy : m1_busy;
  endfunction

  function automatic void expect_txn(input int m, input logic rd, input logic [AW-1:0] addr,
                                     input logic [BN-1:0] be, input logic [DW-1:0] wd,
                                     input logic [DW-1:0] rdata, input int blen);
    txn_t e;
    e.rd    = rd;
    e.addr  = addr;
    e.be    = be;
    e.wd    = wd;
    e.rdata = rdata;
    e.grant = (m == 0) ? GRANT_M0 : GRANT_M1;
    e.blen  = blen;
    sb_q.push_back(e);
  endfunction

  // Slave model: accepts on the falling edge, holds busy for blen cycles, returns read data.
  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_active    <= 1'b0;
      s_cnt       <= 0;
      mem_busy    <= 1'b0;
      mem_rd_data <= '0;
    end else if (!s_active) begin
      if (mem_rd_en || mem_wr_en) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_txn", sb_q.size(), 1);
        end else begin
          check("sb_rd_en",   mem_rd_en,   sb_q[0].rd);
          check("sb_wr_en",   mem_wr_en,   !sb_q[0].rd);
          check("sb_addr",    mem_addr,    sb_q[0].addr);
          check("sb_byte_en", mem_byte_en, sb_q[0].be);
          check("sb_wr_data", mem_wr_data, sb_q[0].wd);
          check("sb_grant",   grant,       sb_q[0].grant);
          mem_rd_data <= sb_q[0].rdata;
          s_cnt       <= sb_q[0].blen - 1;
          void'(sb_q.pop_front());
        end
        mem_busy <= 1'b1;
        s_active <= 1'b1;
      end
    end else if (s_cnt == 0) begin
      mem_busy <= 1'b0;
      s_active <= 1'b0;
    end else begin
      s_cnt <= s_cnt - 1;
    end
  end

  always @(posedge clock) begin
    #3;
    check("m0_busy_mirror", m0_busy, mem_busy & grant[0]);
    check("m1_busy_mirror", m1_busy, mem_busy & grant[1]);
    check("grant_onehot0", $onehot0(grant), 1);
    assert (!(m_rd[0] && m_wr[0]) && !(m_rd[1] && m_wr[1]))
      else $error("illegal stimulus: rd_en and wr_en together");
  end

  initial begin
    #(HALF * 2 * 20000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Caller is at a drive point; returns one time unit after the master saw busy fall.
  task automatic run_txn(input int m, input logic rd, input logic [AW-1:0] addr,
                         input logic [BN-1:0] be, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rexp, input bit keep);
    bit            seen;
    bit            done;
    logic [DW-1:0] rd_cap;
    seen      = 1'b0;
    done      = 1'b0;
    rd_cap    = '0;
    m_rd[m]   = rd;
    m_wr[m]   = !rd;
    m_be[m]   = be;
    m_addr[m] = addr;
    m_wd[m]   = wd;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clock);
      #3;
      if (busy_of(m)) begin
        seen   = 1'b1;
        rd_cap = rd_data;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    check($sformatf("m%0d_txn_done", m), done, 1);
    if (rd) check($sformatf("m%0d_rd_data", m), rd_cap, rexp);
    #1;
    if (!keep) begin
      m_rd[m] = 1'b0;
      m_wr[m] = 1'b0;
    end
  endtask

  task automatic wait_busy(input int m, input logic level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clock);
      #3;
      if (busy_of(m) == level) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #5 reset_n = 1'b0;
    @(posedge clock);
    #5 reset_n = 1'b1;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_rd[m]   = 1'b0;
      m_wr[m]   = 1'b0;
      m_be[m]   = '0;
      m_addr[m] = '0;
      m_wd[m]   = '0;
    end
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_grant", grant, GRANT_NONE);
    check("rst_mem_ctrl", {mem_rd_en, mem_wr_en}, 0);
    check("rst_busy", {m0_busy, m1_busy}, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #3;
      check("t1_grant", grant, GRANT_NONE);
      check("t1_mem_ctrl", {mem_rd_en, mem_wr_en}, 0);
      check("t1_mem_addr", mem_addr, 0);
      check("t1_mem_be", mem_byte_en, 0);
      check("t1_mem_wd", mem_wr_data, 0);
    end

    // Single m0 read, one-cycle forwarding latency
    @(posedge clock);
    #1;
    expect_txn(0, 1'b1, 64'h1000, 8'h0F, '0, 64'hDEAD_BEEF, 3);
    fork
      run_txn(0, 1'b1, 64'h1000, 8'h0F, '0, 64'hDEAD_BEEF, 1'b0);
      begin
        #2;
        check("t2_rd_en_before", mem_rd_en, 0);
        @(posedge clock);
        #3;
        check("t2_rd_en_after", mem_rd_en, 1);
        check("t2_grant", grant, GRANT_M0);
        check("t2_addr", mem_addr, 64'h1000);
        check("t2_be", mem_byte_en, 8'h0F);
      end
    join
    check("t2_back_idle_grant", grant, GRANT_NONE);
    check("t2_back_idle_rd_en", mem_rd_en, 0);
    check("t2_sb_drained", sb_q.size(), 0);

    // Simultaneous requests; m0 issues two back-to-back, m1 one
    do_reset();
    @(posedge clock);
    #1;
`ifdef ARBITER_ROUND_ROBIN_EN
    expect_txn(0, 1'b1, 64'h1100, 8'hFF, '0, 64'hA1, 2);
    expect_txn(1, 1'b1, 64'h2100, 8'hFF, '0, 64'hC3, 2);
    expect_txn(0, 1'b0, 64'h1200, 8'h33, 64'hB2, '0, 1);
`else
    expect_txn(0, 1'b1, 64'h1100, 8'hFF, '0, 64'hA1, 2);
    expect_txn(0, 1'b0, 64'h1200, 8'h33, 64'hB2, '0, 1);
    expect_txn(1, 1'b1, 64'h2100, 8'hFF, '0, 64'hC3, 2);
`endif
    fork
      begin
        run_txn(0, 1'b1, 64'h1100, 8'hFF, '0, 64'hA1, 1'b1);
        run_txn(0, 1'b0, 64'h1200, 8'h33, 64'hB2, '0, 1'b0);
      end
      run_txn(1, 1'b1, 64'h2100, 8'hFF, '0, 64'hC3, 1'b0);
    join
    check("t3_sb_drained", sb_q.size(), 0);

    // m1 write held while m0 read is busy, issued after one idle cycle
    @(posedge clock);
    #1;
    expect_txn(0, 1'b1, 64'h1000, 8'hFF, '0, 64'h1234_5678, 4);
    expect_txn(1, 1'b0, 64'h2000, 8'hFF, 64'h55AA, '0, 2);
    fork
      run_txn(0, 1'b1, 64'h1000, 8'hFF, '0, 64'h1234_5678, 1'b0);
      begin
        wait_busy(0, 1'b1, ok_a);
        check("t4_m0_busy_seen", ok_a, 1);
        @(posedge clock);
        #1;
        run_txn(1, 1'b0, 64'h2000, 8'hFF, 64'h55AA, '0, 1'b0);
      end
      begin
        wait_busy(0, 1'b1, ok_b);
        wait_busy(0, 1'b0, ok_c);
        check("t4_m0_busy_fell", ok_c, 1);
        check("t4_gap_grant", grant, GRANT_NONE);
        check("t4_gap_wr_en", mem_wr_en, 0);
        @(posedge clock);
        #3;
        check("t4_m1_grant", grant, GRANT_M1);
        check("t4_m1_wr_en", mem_wr_en, 1);
        check("t4_m1_wr_data", mem_wr_data, 64'h55AA);
        check("t4_m1_be", mem_byte_en, 8'hFF);
      end
    join

    // Reset pulse during BUSY abandons m0; pending m1 is granted after release
    @(posedge clock);
    #1;
    expect_txn(0, 1'b1, 64'h3000, 8'hFF, '0, 64'h77, 4);
    m_rd[0]   = 1'b1;
    m_addr[0] = 64'h3000;
    m_be[0]   = 8'hFF;
    m_wd[0]   = '0;
    wait_busy(0, 1'b1, ok_a);
    check("t5_m0_busy_seen", ok_a, 1);
    expect_txn(1, 1'b0, 64'h3800, 8'h3C, 64'h99, '0, 2);
    m_wr[1]   = 1'b1;
    m_addr[1] = 64'h3800;
    m_be[1]   = 8'h3C;
    m_wd[1]   = 64'h99;
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_grant", grant, GRANT_NONE);
    check("t5_rst_mem_ctrl", {mem_rd_en, mem_wr_en}, 0);
    check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_mem_be", mem_byte_en, 0);
    check("t5_rst_busy", {m0_busy, m1_busy}, 0);
    m_rd[0] = 1'b0;
    @(posedge clock);
    #3;
    check("t5_rst_hold_grant", grant, GRANT_NONE);
    #2 reset_n = 1'b1;
    #1;
    run_txn(1, 1'b0, 64'h3800, 8'h3C, 64'h99, '0, 1'b0);

    // m0 aborts in REQ before busy; m1 goes next
    @(posedge clock);
    #1;
    m_rd[0]   = 1'b1;
    m_addr[0] = 64'h5000;
    m_be[0]   = 8'hF0;
    @(posedge clock);
    #3;
    check("t6_req_grant", grant, GRANT_M0);
    check("t6_req_rd_en", mem_rd_en, 1);
    check("t6_req_no_busy", mem_busy, 0);
    #1;
    m_rd[0] = 1'b0;
    expect_txn(1, 1'b1, 64'h6000, 8'h0F, '0, 64'hABCD, 1);
    m_rd[1]   = 1'b1;
    m_addr[1] = 64'h6000;
    m_be[1]   = 8'h0F;
    m_wd[1]   = '0;
    @(posedge clock);
    #3;
    check("t6_abort_grant", grant, GRANT_NONE);
    check("t6_abort_no_busy", mem_busy, 0);
    run_txn(1, 1'b1, 64'h6000, 8'h0F, '0, 64'hABCD, 1'b0);

    check("final_sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
